// File: rtl/psum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cim_pkg
// Description : Shared constants, FSM state type and PSUM lane helpers for
//               the PSUM accumulator and its quantizer lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package cim_pkg;

  localparam int N_LANE = 72;
  localparam int PSUM_W = 14;
  localparam int ACC_W  = 20;
  localparam int OUT_W  = 4;
  localparam int CNT_W  = 7;   // holds 0..64

  // Largest value an unsigned OUT_W lane can carry, in accumulator format
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  // Extract PSUM lane idx from the packed bus and sign-extend it to ACC_W
  function automatic logic signed [ACC_W-1:0] psum_lane_ext(
    input logic [N_LANE*PSUM_W-1:0] bus,
    input int                       idx
  );
    logic [PSUM_W-1:0] v;
    v = bus[PSUM_W*idx +: PSUM_W];
    return {{(ACC_W-PSUM_W){v[PSUM_W-1]}}, v};
  endfunction

  // Number of beats a run accumulates; a programmed 0 means 64
  function automatic logic [CNT_W-1:0] beats_target(input logic [5:0] passes);
    return (passes == 6'd0) ? CNT_W'(64) : {1'b0, passes};
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_accumulator_quant.sv
`default_nettype none
// ============================================================================
// Module      : psum_quant_lane
// Description : Combinational ReLU, arithmetic right shift and unsigned
//               saturation of one accumulated lane to OUT_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_quant_lane
  import cim_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [3:0]       shift_i,
  input  logic                    relu_i,
  output logic        [OUT_W-1:0] q_o
);

  logic signed [ACC_W-1:0] relu_w;
  logic signed [ACC_W-1:0] shifted_w;

  // relu -> arithmetic shift (truncating toward -inf) -> clamp to [0, OUT_MAX]
  always_comb begin
    relu_w    = (relu_i && acc_i[ACC_W-1]) ? '0 : acc_i;
    shifted_w = relu_w >>> shift_i;
    if (shifted_w[ACC_W-1]) begin
      q_o = '0;
    end else if (shifted_w > OUT_MAX) begin
      q_o = '1;
    end else begin
      q_o = shifted_w[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : psum_accumulator
// Description : Accumulates the 72-lane signed PSUM bus over a programmed
//               number of beats, then quantizes each lane to 4b unsigned and
//               hands the 288b result out through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_accumulator
  import cim_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic [5:0]                 cfg_passes,
  input  logic [3:0]                 cfg_shift,
  input  logic                       cfg_relu,
  input  logic                       psum_valid,
  output logic                       psum_ready,
  input  logic [N_LANE*PSUM_W-1:0]   psum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_LANE*OUT_W-1:0]    out_data,
  output logic                       busy,
  output logic                       done
);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q [N_LANE];
  logic signed [ACC_W-1:0] acc_d [N_LANE];
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [5:0]              passes_q;
  logic [3:0]              shift_q;
  logic                    relu_q;
  logic                    psum_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    beat_w;
  logic                    last_beat_w;

  // Candidate sums and beat bookkeeping for a beat accepted this cycle
  always_comb begin
    for (int i = 0; i < N_LANE; i++) begin
      acc_d[i] = acc_q[i] + psum_lane_ext(psum, i);
    end
    cnt_d       = cnt_q + CNT_W'(1);
    beat_w      = psum_valid && psum_ready_q;
    last_beat_w = (cnt_d == beats_target(passes_q));
  end

  // Control FSM, accumulators and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      passes_q     <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      psum_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < N_LANE; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            passes_q     <= cfg_passes;
            shift_q      <= cfg_shift;
            relu_q       <= cfg_relu;
            cnt_q        <= '0;
            for (int i = 0; i < N_LANE; i++) begin
              acc_q[i] <= '0;
            end
            state_q      <= ST_ACCUM;
            psum_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (beat_w) begin
            for (int i = 0; i < N_LANE; i++) begin
              acc_q[i] <= acc_d[i];
            end
            cnt_q <= cnt_d;
            if (last_beat_w) begin
              state_q      <= ST_OUTPUT;
              psum_ready_q <= 1'b0;
              out_valid_q  <= 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          if (out_valid_q && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          psum_ready_q <= 1'b0;
          out_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign psum_ready = psum_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  // done must coincide with the handshake cycle itself, so it is not delayed
  assign done       = out_valid_q && out_ready;

  // One quantizer per lane; data is forced to zero when no result is offered
  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    logic [OUT_W-1:0] q_w;
    psum_quant_lane u_quant (
      .acc_i   (acc_q[i]),
      .shift_i (shift_q),
      .relu_i  (relu_q),
      .q_o     (q_w)
    );
    assign out_data[OUT_W*i +: OUT_W] = out_valid_q ? q_w : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_accumulator
// Description : Directed, table-driven self-checking bench for
//               psum_accumulator plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;
  import cim_pkg::*;

  localparam int PB = N_LANE*PSUM_W;
  localparam int OB = N_LANE*OUT_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [5:0]    cfg_passes;
  logic [3:0]    cfg_shift;
  logic          cfg_relu;
  logic          psum_valid;
  logic          psum_ready;
  logic [PB-1:0] psum;
  logic          out_valid;
  logic          out_ready;
  logic [OB-1:0] out_data;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_passes (cfg_passes),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum       (psum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [5:0] passes;
    logic [3:0] shift;
    logic       relu;
    int         v0;
    int         v1;
    int         vo;
    logic [3:0] e0;
    logic [3:0] e1;
    logic [3:0] eo;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [PB-1:0] mk_bus(input int v0, input int v1, input int vo);
    logic [PB-1:0] b;
    int            v;
    b = '0;
    for (int i = 0; i < N_LANE; i++) begin
      v = (i == 0) ? v0 : ((i == 1) ? v1 : vo);
      b[PSUM_W*i +: PSUM_W] = PSUM_W'(v);
    end
    return b;
  endfunction

  function automatic logic [OB-1:0] mk_out(input logic [3:0] e0, input logic [3:0] e1,
                                           input logic [3:0] eo);
    logic [OB-1:0] b;
    for (int i = 0; i < N_LANE; i++) begin
      b[OUT_W*i +: OUT_W] = (i == 0) ? e0 : ((i == 1) ? e1 : eo);
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [OB-1:0] act, input logic [OB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [5:0] passes, input logic [3:0] shift, input logic relu);
    @(posedge clk); #1;
    cfg_start  = 1'b1;
    cfg_passes = passes;
    cfg_shift  = shift;
    cfg_relu   = relu;
    @(posedge clk); #1;
    cfg_start  = 1'b0;
  endtask

  // Full run with a constant PSUM pattern; checks latency, data, done and busy
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    n = (v.passes == 6'd0) ? 64 : int'(v.passes);
    start_run(v.passes, v.shift, v.relu);
    check($sformatf("v%0d psum_ready in ACCUM", idx), OB'(psum_ready), OB'(1));
    psum       = mk_bus(v.v0, v.v1, v.vo);
    psum_valid = 1'b1;
    for (int b = 0; b < n; b++) begin
      if (b == n - 1) check($sformatf("v%0d out_valid before last beat", idx), OB'(out_valid), OB'(0));
      @(posedge clk); #1;
    end
    psum_valid = 1'b0;
    check($sformatf("v%0d out_valid latency", idx), OB'(out_valid), OB'(1));
    check($sformatf("v%0d out_data", idx), out_data, mk_out(v.e0, v.e1, v.eo));
    out_ready = 1'b1;
    #3;
    check($sformatf("v%0d done on handshake", idx), OB'(done), OB'(1));
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("v%0d busy after done", idx), OB'({busy, done, out_valid}), OB'(0));
  endtask

  initial begin
    logic [OB-1:0] exp_o;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_passes = '0; cfg_shift = '0; cfg_relu = 1'b0;
    psum_valid = 1'b0; psum = '0; out_ready = 1'b0;

    vecs[0] = '{6'd4, 4'd4,  1'b0,   64,    64,  64, 4'd15, 4'd15, 4'd15};
    vecs[1] = '{6'd2, 4'd1,  1'b0,    3,     5,   0, 4'd3,  4'd5,  4'd0};
    vecs[2] = '{6'd1, 4'd0,  1'b1,  -20,     0,   0, 4'd0,  4'd0,  4'd0};
    vecs[3] = '{6'd1, 4'd2,  1'b0,  -20,    13,   0, 4'd0,  4'd3,  4'd0};
    vecs[4] = '{6'd0, 4'd15, 1'b0, 8191, -8192,   1, 4'd15, 4'd0,  4'd0};
    vecs[5] = '{6'd3, 4'd2,  1'b0,    5,     7,   4, 4'd3,  4'd5,  4'd3};
    vecs[6] = '{6'd1, 4'd0,  1'b1,    7, -8192,  15, 4'd7,  4'd0,  4'd15};

    #12;
    check("reset outputs", OB'({psum_ready, out_valid, busy, done}), OB'(0));
    check("reset out_data", out_data, '0);
    rst_n = 1'b1;

    // psum_valid in IDLE must not be accepted
    psum = mk_bus(100, 100, 100); psum_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psum_valid = 1'b0;
    check("idle psum_ready", OB'({psum_ready, busy}), OB'(0));

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Backpressure: result holds while out_ready is low, extra beats ignored
    start_run(6'd1, 4'd0, 1'b0);
    psum = mk_bus(7, 0, 0); psum_valid = 1'b1;
    @(posedge clk); #1;
    psum = mk_bus(1000, 1000, 1000);
    exp_o = mk_out(4'd7, 4'd0, 4'd0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d valid/ready/done", c), OB'({out_valid, psum_ready, done}), OB'(3'b100));
      check($sformatf("bp%0d out_data", c), out_data, exp_o);
      @(posedge clk); #1;
    end
    psum_valid = 1'b0;
    out_ready  = 1'b1;
    #3;
    check("bp done", OB'(done), OB'(1));
    check("bp out_data at handshake", out_data, exp_o);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp idle", OB'({busy, out_valid}), OB'(0));

    // Stalls and gaps: valid 1,0,0,1,1 then a beat on the transition cycle
    start_run(6'd3, 4'd0, 1'b0);
    begin
      logic [4:0] pat;
      int         val [5];
      pat = 5'b11001;
      val = '{2, 100, 100, 3, 4};
      for (int c = 0; c < 5; c++) begin
        psum_valid = pat[c];
        psum       = mk_bus(val[c], 1, 0);
        @(posedge clk); #1;
      end
    end
    check("gap out_valid", OB'(out_valid), OB'(1));
    psum = mk_bus(5, 5, 5); psum_valid = 1'b1;
    @(posedge clk); #1;
    psum_valid = 1'b0;
    check("gap out_data", out_data, mk_out(4'd9, 4'd3, 4'd0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset mid-ACCUM after 2 of 4 beats, then a clean run
    start_run(6'd4, 4'd0, 1'b0);
    psum = mk_bus(5, 5, 5); psum_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psum_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midreset flags", OB'({psum_ready, out_valid, busy, done}), OB'(0));
    check("midreset out_data", out_data, '0);
    #3;
    rst_n = 1'b1;
    begin
      vec_t v;
      v = '{6'd1, 4'd0, 1'b0, 7, 0, 0, 4'd7, 4'd0, 4'd0};
      run_vec(v, 99);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
